product_accumulator: RTL and testbench

//  Downstream stage of the 16x16 signed multiplier. Takes a stream of 32-bit signed

---
 rtl/product_accumulator.sv | 136 +++++++++++++
 tb/tb_product_accumulator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// ============================================================================
// Module   : product_accumulator
// Brief    : Sums blocks of LEN signed products into a saturating accumulator
//            and presents the block total on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_accumulator #(
  parameter int PW = 32,
  parameter int AW = 40,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_acc,
  output logic          out_sat,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [LW-1:0] c_cnt_one = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] c_acc_max = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] c_acc_min = {1'b1, {(AW-1){1'b0}}};

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_acc, w_acc_nxt;
  logic [LW-1:0] r_cnt, w_cnt_nxt;
  logic [LW-1:0] r_len, w_len_nxt;
  logic          r_sat, w_sat_nxt;
  logic          r_in_ready, w_in_ready_nxt;
  logic          r_out_valid, w_out_valid_nxt;

  logic [AW:0]   w_sum;
  logic          w_clamp;
  logic [AW-1:0] w_sat_sum;
  logic          w_accept;

  // Exact sum one bit wider than the accumulator; top two bits disagreeing means overflow.
  assign w_sum     = {r_acc[AW-1], r_acc} + {{(AW+1-PW){in_prod[PW-1]}}, in_prod};
  assign w_clamp   = w_sum[AW] ^ w_sum[AW-1];
  assign w_sat_sum = w_clamp ? (w_sum[AW] ? c_acc_min : c_acc_max) : w_sum[AW-1:0];
  assign w_accept  = in_valid & r_in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_sat       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len       <= w_len_nxt;
      r_sat       <= w_sat_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_len_nxt       = r_len;
    w_sat_nxt       = r_sat;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc_nxt = '0;
          w_sat_nxt = 1'b0;
          w_cnt_nxt = '0;
          if (len != '0) begin
            w_len_nxt      = len;
            w_state_nxt    = S_ACCUM;
            w_in_ready_nxt = 1'b1;
          end else begin
            w_state_nxt     = S_HOLD;
            w_out_valid_nxt = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_acc_nxt = w_sat_sum;
          w_sat_nxt = r_sat | w_clamp;
          w_cnt_nxt = r_cnt + c_cnt_one;
          if ((r_cnt + c_cnt_one) == r_len) begin
            w_state_nxt     = S_HOLD;
            w_in_ready_nxt  = 1'b0;
            w_out_valid_nxt = 1'b1;
          end
        end
      end
      S_HOLD: begin
        // A start arriving with out_ready is dropped; IDLE needs a fresh start.
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_acc   = r_acc;
  assign out_sat   = r_sat;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
// Module   : tb_product_accumulator
// Brief    : Directed checks of product_accumulator at AW=40 and AW=34 in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, out_ready;
  logic [7:0]  len;
  logic [31:0] in_prod;

  logic        in_ready40, out_valid40, out_sat40, busy40;
  logic [39:0] out_acc40;
  logic        in_ready34, out_valid34, out_sat34, busy34;
  logic [33:0] out_acc34;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  product_accumulator u_dut40 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready40), .in_prod(in_prod),
    .out_valid(out_valid40), .out_ready(out_ready), .out_acc(out_acc40),
    .out_sat(out_sat40), .busy(busy40)
  );

  product_accumulator #(.AW(34)) u_dut34 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready34), .in_prod(in_prod),
    .out_valid(out_valid34), .out_ready(out_ready), .out_acc(out_acc34),
    .out_sat(out_sat34), .busy(busy34)
  );

  typedef struct packed {
    logic [7:0]       len;
    logic [5:0][31:0] p;
    logic [39:0]      e40;
    logic             s40;
    logic [33:0]      e34;
    logic             s34;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic [7:0] l,
                              input logic [31:0] a, b, c, d, e, f,
                              input logic [39:0] e40, input logic s40,
                              input logic [33:0] e34, input logic s34);
    vec_t v;
    v.len = l;
    v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d; v.p[4] = e; v.p[5] = f;
    v.e40 = e40; v.s40 = s40; v.e34 = e34; v.s34 = s34;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    start = 1'b1;
    len   = v.len;
    step();
    start = 1'b0;
    chk("in_ready_rise40", 64'(in_ready40), 64'd1);
    chk("in_ready_rise34", 64'(in_ready34), 64'd1);
    for (int i = 0; i < int'(v.len); i++) begin
      in_valid = 1'b1;
      in_prod  = v.p[i];
      step();
    end
    in_valid = 1'b0;
    in_prod  = 32'hDEAD_BEEF;
    chk("latency_out_valid40", 64'(out_valid40), 64'd1);
    chk("latency_out_valid34", 64'(out_valid34), 64'd1);
    chk("hold_in_ready", 64'(in_ready40), 64'd0);
    chk("acc40", 64'(out_acc40), 64'(v.e40));
    chk("sat40", 64'(out_sat40), 64'(v.s40));
    chk("acc34", 64'(out_acc34), 64'(v.e34));
    chk("sat34", 64'(out_sat34), 64'(v.s34));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("drain_out_valid", 64'(out_valid40), 64'd0);
    chk("drain_busy", 64'({busy40, busy34}), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    vecs[0] = mk(8'd3, 32'd6, 32'hFFFF_FFFC, 32'd16, 0, 0, 0, 40'd18, 1'b0, 34'd18, 1'b0);
    vecs[1] = mk(8'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0,
                 40'h02_7FFF_FFFB, 1'b0, 34'h1_FFFF_FFFF, 1'b1);
    vecs[2] = mk(8'd4, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0,
                 40'h01_FFFF_FFFC, 1'b0, 34'h1_FFFF_FFFC, 1'b0);
    vecs[3] = mk(8'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0,
                 40'hFD_8000_0000, 1'b0, 34'h2_0000_0000, 1'b1);
    vecs[4] = mk(8'd1, 32'd1, 0, 0, 0, 0, 0, 40'd1, 1'b0, 34'd1, 1'b0);
    vecs[5] = mk(8'd2, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, 0,
                 40'hFF_7FFF_FFFF, 1'b0, 34'h3_7FFF_FFFF, 1'b0);
    // Clamp at max, then a negative product must pull down from the clamped value.
    vecs[6] = mk(8'd6, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                 32'h8000_0000, 40'h01_FFFF_FFFB, 1'b0, 34'h1_7FFF_FFFF, 1'b1);

    rst_n = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_prod = 32'd0; out_ready = 1'b0;
    step();
    step();
    chk("rst_busy", 64'({busy40, busy34}), 64'd0);
    chk("rst_in_ready", 64'({in_ready40, in_ready34}), 64'd0);
    chk("rst_out_valid", 64'({out_valid40, out_valid34}), 64'd0);
    chk("rst_acc", 64'(out_acc40) | 64'(out_acc34), 64'd0);
    chk("rst_sat", 64'({out_sat40, out_sat34}), 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", 64'(in_ready40), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Alternating in_valid, long back-pressure in HOLD, start ignored outside IDLE.
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    accepts = 0;
    for (int k = 0; k < 20 && !out_valid40; k++) begin
      in_valid = (k % 2 == 0);
      in_prod  = in_valid ? 32'(10 * (accepts + 1)) : 32'd999;
      if (in_valid && in_ready40) accepts++;
      step();
    end
    in_valid = 1'b0;
    chk("toggle_out_valid", 64'(out_valid40), 64'd1);
    chk("toggle_accepts", 64'(accepts), 64'd4);
    chk("toggle_acc", 64'(out_acc40), 64'd100);
    for (int j = 0; j < 10; j++) begin
      start = (j == 3); len = 8'd7; in_valid = 1'b1; in_prod = 32'd5;
      step();
      chk("hold_valid", 64'(out_valid40), 64'd1);
      chk("hold_acc", 64'(out_acc40), 64'd100);
      chk("hold_no_ready", 64'(in_ready40), 64'd0);
    end
    in_valid = 1'b0;
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    chk("hold_exit_busy", 64'(busy40), 64'd0);
    chk("hold_exit_valid", 64'(out_valid40), 64'd0);
    chk("idle_retains_acc", 64'(out_acc40), 64'd100);
    step();
    chk("same_cycle_start_dropped", 64'(busy40), 64'd0);

    // Zero-length block goes straight to HOLD with a cleared total.
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0;
    chk("len0_out_valid", 64'(out_valid40), 64'd1);
    chk("len0_acc", 64'(out_acc40), 64'd0);
    chk("len0_sat", 64'(out_sat40), 64'd0);
    chk("len0_no_ready", 64'(in_ready40), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("len0_drain", 64'(busy40), 64'd0);

    // Reset mid-block after two of five products.
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0; in_valid = 1'b1; in_prod = 32'd3;
    step();
    in_prod = 32'd4;
    step();
    chk("mid_acc", 64'(out_acc40), 64'd7);
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_busy", 64'({busy40, busy34}), 64'd0);
    chk("midrst_ready", 64'(in_ready40), 64'd0);
    chk("midrst_acc", 64'(out_acc40), 64'd0);
    chk("midrst_valid", 64'(out_valid40), 64'd0);
    run_vec(mk(8'd2, 32'd7, 32'd8, 0, 0, 0, 0, 40'd15, 1'b0, 34'd15, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
